// File: rtl/seq_restoring_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock.
// Ports: clk/rst (sync, active-high); in_valid/in_ready with dividend and
//   divisor; out_valid/out_ready with quotient, remainder, div_by_zero.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int N  = WIDTH + 1;
    localparam int LV = $clog2(N);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // Trial subtraction datapath
    logic [N-1:0]       rs;
    logic [N-1:0]       sub_b;
    logic [N-1:0]       g, p;
    logic [LV:0][N-1:0] gk;
    logic [LV:0][N-1:0] pk;
    logic [WIDTH-1:0]   diff;
    logic               no_borrow;

    assign rs    = {r_q, dq_q[WIDTH-1]};
    assign sub_b = ~{1'b0, dvs_q};

    // Kogge-Stone carry lookahead; the carry-in of 1 is folded into
    // the bit-0 generate so the prefix tree yields carries directly.
    always_comb begin
        g      = rs & sub_b;
        p      = rs ^ sub_b;
        gk     = '0;
        pk     = '0;
        gk[0]  = g;
        gk[0][0] = g[0] | p[0];
        pk[0]  = p;
        for (int l = 0; l < LV; l++) begin
            for (int i = 0; i < N; i++) begin
                if (i >= (1 << l)) begin
                    gk[l+1][i] = gk[l][i]
                               | (pk[l][i] & gk[l][i-(1<<l)]);
                    pk[l+1][i] = pk[l][i] & pk[l][i-(1<<l)];
                end else begin
                    gk[l+1][i] = gk[l][i];
                    pk[l+1][i] = pk[l][i];
                end
            end
        end
        diff[0] = p[0] ^ 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            diff[i] = p[i] ^ gk[LV][i-1];
        end
        no_borrow = gk[LV][N-1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dq_d  = dividend;
                    dvs_d = divisor;
                    r_d   = '0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        cnt_d   = CW'(WIDTH - 1);
                    end
                end
            end
            RUN: begin
                // A carry-out means the trial difference is non-negative.
                r_d  = no_borrow ? diff : rs[WIDTH-1:0];
                dq_d = {dq_q[WIDTH-2:0], no_borrow};
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quot_d  = dq_d;
                    rem_d   = r_d;
                    dbz_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
